// File: rtl/evm_pkg.sv
// Shared types and helpers for the ballot controller: FSM state encoding,
// derived widths and the one-hot select check.
package evm_pkg;

  localparam int MAX_CAND = 16;

  typedef enum logic [2:0] {
    S_CLOSED,
    S_IDLE,
    S_SEL,
    S_COMMIT,
    S_SCAN,
    S_DONE
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int tot_w(input int n, input int cw);
    return cw + $clog2(n);
  endfunction

  function automatic logic is_onehot(input logic [MAX_CAND-1:0] v);
    return ($countones(v) == 1);
  endfunction

endpackage

// File: rtl/evm_winner_scan.sv
// Sequential winner search over the packed tallies: one candidate per cycle,
// lowest index wins on equal counts, tie flags any later equal maximum.
module evm_winner_scan
  import evm_pkg::*;
#(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       clr,
  input  logic [NUM_CAND*CNT_W-1:0]  tally,
  output logic                       busy,
  output logic                       done,
  output logic [idx_w(NUM_CAND)-1:0] winner,
  output logic                       tie
);

  localparam int IW = idx_w(NUM_CAND);
  localparam logic [IW-1:0] LAST = IW'(NUM_CAND - 1);

  logic [IW-1:0]    idx;
  logic [CNT_W-1:0] cur;
  logic [CNT_W-1:0] run_max, nxt_max;
  logic [IW-1:0]    run_win, nxt_win;
  logic             run_tie, nxt_tie;

  // idx rests at 0 while idle, so the start cycle folds in candidate 0
  assign cur  = tally[idx*CNT_W +: CNT_W];
  assign done = busy && (idx == LAST);

  always_comb begin
    nxt_max = run_max;
    nxt_win = run_win;
    nxt_tie = run_tie;
    if (!busy) begin
      nxt_max = cur;
      nxt_win = '0;
      nxt_tie = 1'b0;
    end else if (cur > run_max) begin
      nxt_max = cur;
      nxt_win = idx;
      nxt_tie = 1'b0;
    end else if (cur == run_max) begin
      nxt_tie = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy   <= 1'b0;
      idx    <= '0;
      winner <= '0;
      tie    <= 1'b0;
    end else begin
      if (start && !busy) begin
        busy <= 1'b1;
        idx  <= IW'(1);
      end else if (done) begin
        busy   <= 1'b0;
        idx    <= '0;
        winner <= nxt_win;
        tie    <= nxt_tie;
      end else if (busy) begin
        idx <= idx + IW'(1);
      end
      if (clr) begin
        winner <= '0;
        tie    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start || busy) begin
      run_max <= nxt_max;
      run_win <= nxt_win;
      run_tie <= nxt_tie;
    end
  end

endmodule

// File: rtl/evm_ballot_ctrl.sv
// Voting controller: poll open/close, select->confirm ballot handshake with
// cancel and timeout, saturating tally bank, and winner scan on close.
module evm_ballot_ctrl
  import evm_pkg::*;
#(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 7,
  parameter int SEL_TMO  = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              open_poll,
  input  logic                              close_poll,
  input  logic [NUM_CAND-1:0]               cand_sel,
  input  logic                              confirm,
  input  logic                              cancel,
  output logic [NUM_CAND*CNT_W-1:0]         tally,
  output logic [NUM_CAND-1:0]               sat,
  output logic [tot_w(NUM_CAND,CNT_W)-1:0]  total,
  output logic                              poll_open,
  output logic                              vote_ack,
  output logic                              vote_rej,
  output logic [idx_w(NUM_CAND)-1:0]        winner,
  output logic                              tie,
  output logic                              result_vld
);

  localparam int IW  = idx_w(NUM_CAND);
  localparam int TW  = tot_w(NUM_CAND, CNT_W);
  localparam int TMW = (SEL_TMO > 2) ? $clog2(SEL_TMO) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [TMW-1:0]   TMO_LAST = TMW'(SEL_TMO - 1);

  state_t           state;
  logic [CNT_W-1:0] tally_q [NUM_CAND];
  logic [TW-1:0]    total_q;
  logic [IW-1:0]    sel_idx;
  logic [TMW-1:0]   tmr;
  logic [IW-1:0]    sel_enc;
  logic             sel_ok;
  logic             open_acc;
  logic             scan_start, scan_busy, scan_done;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  for (genvar g = 0; g < NUM_CAND; g++) begin : g_bank
    assign tally[g*CNT_W +: CNT_W] = tally_q[g];
    assign sat[g]                  = (tally_q[g] == CNT_MAX);
  end

  always_comb begin
    sel_enc = '0;
    for (int i = 0; i < NUM_CAND; i++)
      if (cand_sel[i]) sel_enc = IW'(i);
  end

  assign sel_ok     = is_onehot(MAX_CAND'(cand_sel)) && !sat[sel_enc];
  assign open_acc   = open_poll && !close_poll && (state == S_CLOSED || state == S_DONE);
  assign poll_open  = (state == S_IDLE) || (state == S_SEL) || (state == S_COMMIT);
  assign total      = total_q;
  assign scan_start = (state == S_SCAN) && !scan_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_CLOSED;
      total_q    <= '0;
      sel_idx    <= '0;
      tmr        <= '0;
      vote_ack   <= 1'b0;
      vote_rej   <= 1'b0;
      result_vld <= 1'b0;
      for (int i = 0; i < NUM_CAND; i++) tally_q[i] <= '0;
    end else begin
      vote_ack <= 1'b0;
      vote_rej <= 1'b0;
      unique case (state)
        S_CLOSED, S_DONE: begin
          if (open_acc) begin
            state      <= S_IDLE;
            total_q    <= '0;
            result_vld <= 1'b0;
            for (int i = 0; i < NUM_CAND; i++) tally_q[i] <= '0;
          end
        end
        S_IDLE: begin
          if (close_poll) begin
            state <= S_SCAN;
          end else if (|cand_sel) begin
            if (sel_ok) begin
              state   <= S_SEL;
              sel_idx <= sel_enc;
              tmr     <= '0;
            end else begin
              vote_rej <= 1'b1;
            end
          end
        end
        S_SEL: begin
          // close drops the pending selection silently; cancel beats confirm
          if (close_poll)          state <= S_SCAN;
          else if (cancel)         state <= S_IDLE;
          else if (confirm)        state <= S_COMMIT;
          else if (tmr == TMO_LAST) begin
            vote_rej <= 1'b1;
            state    <= S_IDLE;
          end else begin
            tmr <= tmr + TMW'(1);
          end
        end
        S_COMMIT: begin
          tally_q[sel_idx] <= sat_inc(tally_q[sel_idx]);
          total_q          <= total_q + TW'(1);
          vote_ack         <= 1'b1;
          state            <= close_poll ? S_SCAN : S_IDLE;
        end
        S_SCAN: begin
          if (scan_done) begin
            state      <= S_DONE;
            result_vld <= 1'b1;
          end
        end
        default: state <= S_CLOSED;
      endcase
    end
  end

  evm_winner_scan #(
    .NUM_CAND (NUM_CAND),
    .CNT_W    (CNT_W)
  ) u_scan (
    .clk    (clk),
    .reset  (reset),
    .start  (scan_start),
    .clr    (open_acc),
    .tally  (tally),
    .busy   (scan_busy),
    .done   (scan_done),
    .winner (winner),
    .tie    (tie)
  );

endmodule

// File: tb/tb_evm_ballot_ctrl.sv
// Two controllers (7-bit and 3-bit tallies) driven by shared directed and
// random stimulus, compared every cycle against a ballot-level reference model.
module tb_evm_ballot_ctrl;

  localparam int NC  = 4;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic reset, open_poll, close_poll, confirm, cancel;
  logic [NC-1:0] cand_sel;

  logic [NC*7-1:0] tally_a;
  logic [NC*3-1:0] tally_b;
  logic [NC-1:0]   sat_a, sat_b;
  logic [8:0]      total_a;
  logic [4:0]      total_b;
  logic [1:0]      winner_a, winner_b;
  logic poll_open_a, vote_ack_a, vote_rej_a, tie_a, result_vld_a;
  logic poll_open_b, vote_ack_b, vote_rej_b, tie_b, result_vld_b;

  int n_vec = 0;
  int n_err = 0;

  // reference model: per instance [0]=7-bit, [1]=3-bit tallies
  int cmax[2] = '{127, 7};
  int m_tally[2][NC];
  int m_total[2], m_held[2], m_wait[2], m_commit[2], m_scan[2], m_win[2];
  bit m_poll[2], m_res[2], m_tie[2], m_ack[2], m_rej[2];

  always #5 clk = ~clk;

  evm_ballot_ctrl #(.NUM_CAND(NC), .CNT_W(7), .SEL_TMO(TMO)) dut_a (
    .clk(clk), .reset(reset), .open_poll(open_poll), .close_poll(close_poll),
    .cand_sel(cand_sel), .confirm(confirm), .cancel(cancel),
    .tally(tally_a), .sat(sat_a), .total(total_a), .poll_open(poll_open_a),
    .vote_ack(vote_ack_a), .vote_rej(vote_rej_a), .winner(winner_a),
    .tie(tie_a), .result_vld(result_vld_a)
  );

  evm_ballot_ctrl #(.NUM_CAND(NC), .CNT_W(3), .SEL_TMO(TMO)) dut_b (
    .clk(clk), .reset(reset), .open_poll(open_poll), .close_poll(close_poll),
    .cand_sel(cand_sel), .confirm(confirm), .cancel(cancel),
    .tally(tally_b), .sat(sat_b), .total(total_b), .poll_open(poll_open_b),
    .vote_ack(vote_ack_b), .vote_rej(vote_rej_b), .winner(winner_b),
    .tie(tie_b), .result_vld(result_vld_b)
  );

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NC; i++) m_tally[k][i] = 0;
      m_total[k] = 0; m_held[k] = -1; m_wait[k] = 0; m_commit[k] = -1;
      m_scan[k] = 0; m_win[k] = 0; m_poll[k] = 0; m_res[k] = 0;
      m_tie[k] = 0; m_ack[k] = 0; m_rej[k] = 0;
    end
  endtask

  task automatic publish(input int k);
    int mx, cnt;
    mx = 0; cnt = 0;
    for (int i = 0; i < NC; i++) if (m_tally[k][i] > mx) mx = m_tally[k][i];
    m_win[k] = -1;
    for (int i = 0; i < NC; i++)
      if (m_tally[k][i] == mx) begin
        cnt++;
        if (m_win[k] < 0) m_win[k] = i;
      end
    m_tie[k] = (cnt > 1);
    m_res[k] = 1;
  endtask

  // one clock of ballot-level behaviour, from the inputs sampled at this edge
  task automatic model_step(input int k);
    m_ack[k] = 0; m_rej[k] = 0;
    if (m_scan[k] > 0) begin
      m_scan[k]--;
      if (m_scan[k] == 0) publish(k);
    end else if (m_commit[k] >= 0) begin
      if (m_tally[k][m_commit[k]] < cmax[k]) m_tally[k][m_commit[k]]++;
      m_total[k]++; m_ack[k] = 1; m_commit[k] = -1;
      if (close_poll) begin m_poll[k] = 0; m_scan[k] = NC; end
    end else if (m_poll[k]) begin
      if (close_poll) begin
        m_held[k] = -1; m_poll[k] = 0; m_scan[k] = NC;
      end else if (m_held[k] >= 0) begin
        if (cancel) m_held[k] = -1;
        else if (confirm) begin m_commit[k] = m_held[k]; m_held[k] = -1; end
        else if (m_wait[k] == TMO - 1) begin m_rej[k] = 1; m_held[k] = -1; end
        else m_wait[k]++;
      end else if (cand_sel != 0) begin
        if ($countones(cand_sel) == 1 && m_tally[k][$clog2(cand_sel)] < cmax[k]) begin
          m_held[k] = $clog2(cand_sel); m_wait[k] = 0;
        end else m_rej[k] = 1;
      end
    end else if (open_poll && !close_poll) begin
      for (int i = 0; i < NC; i++) m_tally[k][i] = 0;
      m_total[k] = 0; m_res[k] = 0; m_win[k] = 0; m_tie[k] = 0; m_poll[k] = 1;
    end
  endtask

  task automatic check_all();
    logic [63:0] ta, tb2, sa, sb;
    ta = '0; tb2 = '0; sa = '0; sb = '0;
    for (int i = 0; i < NC; i++) begin
      ta[i*7 +: 7]  = 7'(m_tally[0][i]);
      tb2[i*3 +: 3] = 3'(m_tally[1][i]);
      sa[i] = (m_tally[0][i] == cmax[0]);
      sb[i] = (m_tally[1][i] == cmax[1]);
    end
    chk_eq("tally_a", 64'(tally_a), ta);
    chk_eq("tally_b", 64'(tally_b), tb2);
    chk_eq("sat_a", 64'(sat_a), sa);
    chk_eq("sat_b", 64'(sat_b), sb);
    chk_eq("total_a", 64'(total_a), 64'(m_total[0]));
    chk_eq("total_b", 64'(total_b), 64'(m_total[1]));
    chk_eq("poll_open_a", 64'(poll_open_a), 64'(m_poll[0]));
    chk_eq("poll_open_b", 64'(poll_open_b), 64'(m_poll[1]));
    chk_eq("vote_ack_a", 64'(vote_ack_a), 64'(m_ack[0]));
    chk_eq("vote_ack_b", 64'(vote_ack_b), 64'(m_ack[1]));
    chk_eq("vote_rej_a", 64'(vote_rej_a), 64'(m_rej[0]));
    chk_eq("vote_rej_b", 64'(vote_rej_b), 64'(m_rej[1]));
    chk_eq("result_vld_a", 64'(result_vld_a), 64'(m_res[0]));
    chk_eq("result_vld_b", 64'(result_vld_b), 64'(m_res[1]));
    chk_eq("winner_a", 64'(winner_a), 64'(m_win[0]));
    chk_eq("winner_b", 64'(winner_b), 64'(m_win[1]));
    chk_eq("tie_a", 64'(tie_a), 64'(m_tie[0]));
    chk_eq("tie_b", 64'(tie_b), 64'(m_tie[1]));
  endtask

  task automatic cycle(input logic [NC-1:0] s, input logic cf, input logic cn,
                       input logic op, input logic cl);
    cand_sel = s; confirm = cf; cancel = cn; open_poll = op; close_poll = cl;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, 0, 0, 0, 0);
  endtask

  task automatic vote(input int c, input int n);
    for (int i = 0; i < n; i++) begin
      cycle(NC'(1 << c), 0, 0, 0, 0);
      cycle('0, 1, 0, 0, 0);
      cycle('0, 0, 0, 0, 0);
    end
  endtask

  task automatic close_and_scan();
    cycle('0, 0, 0, 0, 1);
    idle(3);
    chk_eq("scan_early_vld", 64'(result_vld_a), 64'd0);
    idle(1);
    chk_eq("scan_vld", 64'(result_vld_a), 64'd1);
  endtask

  task automatic async_reset_check();
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    open_poll = 1'b1;
    @(posedge clk);
    #1;
    check_all();
    open_poll = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; open_poll = 0; close_poll = 0; confirm = 0; cancel = 0; cand_sel = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;

    // basic vote: select cand 2, confirm next cycle
    cycle('0, 0, 0, 1, 0);
    cycle(4'b0100, 0, 0, 0, 0);
    cycle('0, 1, 0, 0, 0);
    chk_eq("basic_ack_pre", 64'(vote_ack_a), 64'd0);
    cycle('0, 0, 0, 0, 0);
    chk_eq("basic_ack", 64'(vote_ack_a), 64'd1);
    chk_eq("basic_tally2", 64'(tally_a[14 +: 7]), 64'd1);
    chk_eq("basic_total", 64'(total_a), 64'd1);

    // guards: multi-hot, cancel+confirm, timeout
    cycle(4'b0110, 0, 0, 0, 0);
    chk_eq("multihot_rej", 64'(vote_rej_a), 64'd1);
    cycle(4'b0001, 0, 0, 0, 0);
    cycle(4'b1000, 1, 1, 0, 0);
    idle(2);
    cycle(4'b0010, 0, 0, 0, 0);
    idle(15);
    chk_eq("tmo_early", 64'(vote_rej_a), 64'd0);
    idle(1);
    chk_eq("tmo_rej", 64'(vote_rej_a), 64'd1);

    // saturation on the 3-bit instance
    vote(1, 8);
    chk_eq("sat_b1", 64'(sat_b[1]), 64'd1);
    chk_eq("sat_b_tally1", 64'(tally_b[3 +: 3]), 64'd7);

    // winner/tie {3,5,5,1}
    close_and_scan();
    cycle('0, 0, 0, 1, 0);
    vote(0, 3); vote(1, 5); vote(2, 5); vote(3, 1);
    close_and_scan();
    chk_eq("tie_win", 64'(winner_a), 64'd1);
    chk_eq("tie_flag", 64'(tie_a), 64'd1);

    // {0,2,9,1}
    cycle('0, 0, 0, 1, 0);
    vote(1, 2); vote(2, 9); vote(3, 1);
    close_and_scan();
    chk_eq("clear_win", 64'(winner_a), 64'd2);
    chk_eq("clear_tie", 64'(tie_a), 64'd0);

    // close during selection, then reopen; then all-zero poll
    cycle('0, 0, 0, 1, 0);
    vote(3, 1);
    cycle(4'b0001, 0, 0, 0, 0);
    cycle('0, 0, 0, 1, 1);
    chk_eq("close_sel_norej", 64'(vote_rej_a), 64'd0);
    idle(5);
    cycle('0, 0, 0, 1, 0);
    close_and_scan();
    chk_eq("zero_win", 64'(winner_a), 64'd0);
    chk_eq("zero_tie", 64'(tie_a), 64'd1);

    // close during commit, ignored opens/closes
    cycle('0, 0, 0, 1, 0);
    cycle(4'b0100, 0, 0, 1, 0);
    cycle('0, 1, 0, 0, 0);
    cycle('0, 0, 0, 0, 1);
    idle(6);
    cycle('0, 0, 0, 1, 1);
    cycle('0, 0, 0, 0, 1);

    // async reset mid-scan and mid-selection
    cycle('0, 0, 0, 1, 0);
    vote(0, 2);
    cycle('0, 0, 0, 0, 1);
    idle(2);
    async_reset_check();
    cycle('0, 0, 0, 1, 0);
    cycle(4'b1000, 0, 0, 0, 0);
    async_reset_check();

    // randomized ballots
    for (int n = 0; n < 1500; n++) begin
      logic [NC-1:0] s;
      int r;
      r = $urandom_range(0, 9);
      if (r < 5)      s = '0;
      else if (r < 9) s = NC'(1 << $urandom_range(0, NC - 1));
      else            s = NC'($urandom);
      cycle(s, ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) < 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
